// File: rtl/noc_vc_rx_endpoint_if.sv
// Link bundle between a switch TX port and its receive endpoint, plus the client output port.
// master: drives the rx_* packet/tag and out_ready, and receives credits and the output packet.
// slave: the endpoint side, which receives rx_* and drives credits and the out_* packet.
interface noc_vc_rx_endpoint_if #(
  parameter int VC_W     = 4,
  parameter int A_W      = 3,
  parameter int D_W      = 32,
  parameter int PACKET_W = A_W + D_W
);
  localparam int VC_IW = (VC_W > 1) ? $clog2(VC_W) : 1;

  logic [VC_W-1:0]     rx_vc_target;
  logic [PACKET_W-1:0] rx_packet;
  logic [VC_W-1:0]     rx_vc_credit_gnt;
  logic                out_valid;
  logic                out_ready;
  logic [PACKET_W-1:0] out_packet;
  logic [VC_IW-1:0]    out_vc;

  modport master (
    output rx_vc_target, rx_packet, out_ready,
    input  rx_vc_credit_gnt, out_valid, out_packet, out_vc
  );

  modport slave (
    input  rx_vc_target, rx_packet, out_ready,
    output rx_vc_credit_gnt, out_valid, out_packet, out_vc
  );
endinterface

// File: rtl/noc_vc_rx_endpoint.sv
// Purpose: credit-based VC receive endpoint; per-VC FIFOs feed a round-robin valid/ready client port.
// Latency: enqueue at edge t is visible at the output in t+1; the credit for a pop is issued in the next cycle.
// Backpressure: the client stalls with out_ready; the selection is locked while it stalls; the sender is paced by credits.
// Ports: clk, rst (sync, active-high), bus (slave: rx_vc_target/rx_packet in, rx_vc_credit_gnt out,
//        out_valid/out_packet/out_vc out, out_ready in), err (sticky protocol-violation flag).
module noc_vc_rx_endpoint #(
  parameter int VC_W          = 4,
  parameter int A_W           = 3,
  parameter int D_W           = 32,
  parameter int PACKET_W      = A_W + D_W,
  parameter int VC_FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  noc_vc_rx_endpoint_if.slave bus,
  output logic                err
);
  localparam int STORE = VC_FIFO_DEPTH - 1;
  localparam int PTR_W = (STORE > 1) ? $clog2(STORE) : 1;
  localparam int CNT_W = $clog2(VC_FIFO_DEPTH);
  localparam int VC_IW = (VC_W > 1) ? $clog2(VC_W) : 1;

  logic [PACKET_W-1:0] mem    [VC_W][STORE];
  logic [PTR_W-1:0]    wr_ptr [VC_W];
  logic [PTR_W-1:0]    rd_ptr [VC_W];
  logic [CNT_W-1:0]    cnt    [VC_W];

  logic [VC_IW-1:0] rr_ptr, lock_vc, pick_vc, sel_vc, idx;
  logic             lock_vld, any_vld, head_vld, deq;
  logic             err_q, malformed, overflow;
  logic [VC_W-1:0]  credit_q, push_req, push, pop, full;

  // Storage is not a power of two, so pointers wrap explicitly.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(STORE - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Round-robin pick: scan downward so the lowest offset from rr_ptr wins.
  always_comb begin
    pick_vc = '0;
    any_vld = 1'b0;
    idx     = '0;
    for (int i = VC_W - 1; i >= 0; i--) begin
      idx = VC_IW'((int'(rr_ptr) + i) % VC_W);
      if (cnt[idx] != '0) begin
        pick_vc = idx;
        any_vld = 1'b1;
      end
    end
  end

  // A stalled head keeps its VC; its FIFO cannot drain without a handshake, so it stays valid.
  assign sel_vc   = lock_vld ? lock_vc : pick_vc;
  assign head_vld = any_vld & ~rst;
  assign deq      = head_vld & bus.out_ready;
  assign pop      = deq ? (VC_W'(1) << sel_vc) : '0;

  // More than one tag bit set means the tag is corrupt; the packet goes nowhere.
  assign malformed = |(bus.rx_vc_target & (bus.rx_vc_target - VC_W'(1)));
  assign push_req  = malformed ? '0 : bus.rx_vc_target;

  always_comb begin
    for (int v = 0; v < VC_W; v++) begin
      full[v] = (cnt[v] == CNT_W'(STORE));
    end
  end

  // A pop on the same VC frees the slot in the same edge, so a full FIFO can still accept.
  assign push     = push_req & (~full | pop);
  assign overflow = |(push_req & full & ~pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int v = 0; v < VC_W; v++) begin
        wr_ptr[v] <= '0;
        rd_ptr[v] <= '0;
        cnt[v]    <= '0;
      end
      rr_ptr   <= '0;
      lock_vld <= 1'b0;
      lock_vc  <= '0;
      credit_q <= '0;
      err_q    <= 1'b0;
    end else begin
      for (int v = 0; v < VC_W; v++) begin
        if (push[v]) wr_ptr[v] <= ptr_inc(wr_ptr[v]);
        if (pop[v])  rd_ptr[v] <= ptr_inc(rd_ptr[v]);
        cnt[v] <= cnt[v] + CNT_W'(push[v]) - CNT_W'(pop[v]);
      end
      if (deq) rr_ptr <= (sel_vc == VC_IW'(VC_W - 1)) ? '0 : sel_vc + VC_IW'(1);
      lock_vld <= head_vld & ~bus.out_ready;
      lock_vc  <= sel_vc;
      credit_q <= pop;
      if (malformed || overflow) err_q <= 1'b1;
    end
  end

  // Payload storage needs no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    for (int v = 0; v < VC_W; v++) begin
      if (!rst && push[v]) mem[v][wr_ptr[v]] <= bus.rx_packet;
    end
  end

  // Outputs come only from registered state; rst forces them low in its own cycle.
  assign bus.out_valid        = head_vld;
  assign bus.out_vc           = head_vld ? sel_vc : '0;
  assign bus.out_packet       = head_vld ? mem[sel_vc][rd_ptr[sel_vc]] : '0;
  assign bus.rx_vc_credit_gnt = credit_q & {VC_W{~rst}};
  assign err                  = err_q & ~rst;
endmodule

// File: tb/tb_noc_vc_rx_endpoint.sv
module tb_noc_vc_rx_endpoint;
  localparam int VC_W = 4;
  localparam int PW   = 35;
  localparam int CAP  = 3;

  logic clk;
  logic rst;
  logic err;

  noc_vc_rx_endpoint_if #(.VC_W(VC_W), .A_W(3), .D_W(32)) bus ();

  noc_vc_rx_endpoint #(.VC_W(VC_W), .A_W(3), .D_W(32), .VC_FIFO_DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave),
    .err (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int errors = 0;
  int checks = 0;

  // Reference model: one queue per VC, round-robin start index, sticky error,
  // pending credit, and the VC shown last cycle if the client stalled on it.
  logic [PW-1:0] mq [VC_W][$];
  int            m_rr;
  bit            m_err;
  logic [3:0]    m_cred;
  bit            m_held;
  int            m_held_vc;

  bit            exp_valid;
  int            exp_vc;
  logic [PW-1:0] exp_pkt;
  logic [3:0]    exp_cred;
  bit            exp_err;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_expect(input logic r);
    int v;
    exp_valid = 1'b0;
    exp_vc    = 0;
    exp_pkt   = '0;
    if (!r) begin
      if (m_held) begin
        exp_valid = 1'b1;
        exp_vc    = m_held_vc;
      end else begin
        for (int i = 0; i < VC_W; i++) begin
          v = (m_rr + i) % VC_W;
          if (!exp_valid && mq[v].size() > 0) begin
            exp_valid = 1'b1;
            exp_vc    = v;
          end
        end
      end
      if (exp_valid) exp_pkt = mq[exp_vc][0];
    end
    exp_cred = r ? 4'b0 : m_cred;
    exp_err  = r ? 1'b0 : m_err;
  endtask

  task automatic model_advance(input logic [3:0] tgt, input logic [PW-1:0] pkt,
                               input logic rdy, input logic r);
    int v;
    logic [PW-1:0] junk;
    if (r) begin
      for (int k = 0; k < VC_W; k++) mq[k].delete();
      m_rr = 0; m_err = 1'b0; m_cred = 4'b0; m_held = 1'b0; m_held_vc = 0;
    end else begin
      m_cred = 4'b0;
      if (exp_valid && rdy) begin
        junk = mq[exp_vc].pop_front();
        m_rr = (exp_vc + 1) % VC_W;
        m_cred[exp_vc] = 1'b1;
      end
      m_held    = exp_valid && !rdy;
      m_held_vc = exp_vc;
      if ($countones(tgt) > 1) begin
        m_err = 1'b1;
      end else if ($countones(tgt) == 1) begin
        v = 0;
        for (int k = 0; k < VC_W; k++) if (tgt[k]) v = k;
        if (mq[v].size() < CAP) mq[v].push_back(pkt);
        else m_err = 1'b1;
      end
    end
  endtask

  // One clock cycle: apply inputs at the falling edge, compare against the model,
  // then let the rising edge happen and return at the next falling edge.
  task automatic step(input logic [3:0] tgt, input logic [PW-1:0] pkt,
                      input logic rdy, input logic r);
    bus.rx_vc_target = tgt;
    bus.rx_packet    = pkt;
    bus.out_ready    = rdy;
    rst              = r;
    #1;
    model_expect(r);
    chk("out_valid",  bus.out_valid, exp_valid);
    chk("out_vc",     bus.out_vc, exp_vc);
    chk("out_packet", bus.out_packet, exp_pkt);
    chk("credit",     bus.rx_vc_credit_gnt, exp_cred);
    chk("err",        err, exp_err);
    model_advance(tgt, pkt, rdy, r);
    @(negedge clk);
  endtask

  int rr_tbl [6] = '{0, 1, 3, 0, 1, 3};

  initial begin
    logic [3:0]    t;
    logic [PW-1:0] p;
    int            a;
    m_rr = 0; m_err = 1'b0; m_cred = 4'b0; m_held = 1'b0; m_held_vc = 0;
    rst = 1'b1;
    bus.rx_vc_target = '0;
    bus.rx_packet    = '0;
    bus.out_ready    = 1'b0;
    @(negedge clk);

    step(4'b0, '0, 1'b0, 1'b1);
    step(4'b0, '0, 1'b0, 1'b1);
    step(4'b0, '0, 1'b1, 1'b0);
    chk("reset_valid", bus.out_valid, 1'b0);
    chk("reset_err", err, 1'b0);

    // Single packet on VC2.
    step(4'b0100, 35'h5A, 1'b1, 1'b0);
    chk("single_valid", bus.out_valid, 1'b1);
    chk("single_vc", bus.out_vc, 2);
    chk("single_pkt", bus.out_packet, 35'h5A);
    step(4'b0, '0, 1'b1, 1'b0);
    chk("single_credit", bus.rx_vc_credit_gnt, 4'b0100);
    step(4'b0, '0, 1'b1, 1'b0);
    chk("single_credit_once", bus.rx_vc_credit_gnt, 4'b0000);

    // Fill VC0 while stalled, then overflow it.
    for (int i = 0; i < 3; i++) begin
      step(4'b0001, 35'hA0 + PW'(i), 1'b0, 1'b0);
      chk("fill_head", bus.out_packet, 35'hA0);
      chk("fill_err", err, 1'b0);
    end
    step(4'b0001, 35'hA3, 1'b0, 1'b0);
    chk("ovf_err", err, 1'b1);
    for (int i = 0; i < 3; i++) begin
      chk("ovf_order", bus.out_packet, 35'hA0 + PW'(i));
      step(4'b0, '0, 1'b1, 1'b0);
      chk("ovf_credit", bus.rx_vc_credit_gnt, 4'b0001);
    end
    chk("ovf_dropped", bus.out_valid, 1'b0);
    step(4'b0, '0, 1'b0, 1'b1);

    // Round-robin across VC0, VC1, VC3.
    for (int i = 0; i < 2; i++) begin
      step(4'b0001, 35'h100 + PW'(i), 1'b0, 1'b0);
      step(4'b0010, 35'h200 + PW'(i), 1'b0, 1'b0);
      step(4'b1000, 35'h300 + PW'(i), 1'b0, 1'b0);
    end
    for (int i = 0; i < 6; i++) begin
      chk("rr_vc", bus.out_vc, rr_tbl[i]);
      step(4'b0, '0, 1'b1, 1'b0);
      chk("rr_credit", bus.rx_vc_credit_gnt, 4'b0001 << rr_tbl[i]);
    end

    // VC1 full, refilled every cycle while draining.
    for (int i = 0; i < 3; i++) step(4'b0010, 35'h400 + PW'(i), 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      chk("full_order", bus.out_packet, 35'h400 + PW'(i));
      step(4'b0010, 35'h403 + PW'(i), 1'b1, 1'b0);
      chk("full_credit", bus.rx_vc_credit_gnt, 4'b0010);
    end
    chk("full_no_err", err, 1'b0);
    for (int i = 0; i < 3; i++) step(4'b0, '0, 1'b1, 1'b0);

    // Malformed tag.
    step(4'b0011, 35'h777, 1'b1, 1'b0);
    chk("malformed_err", err, 1'b1);
    chk("malformed_nowrite", bus.out_valid, 1'b0);
    step(4'b0, '0, 1'b1, 1'b0);
    chk("malformed_sticky", err, 1'b1);

    // Reset with traffic buffered.
    step(4'b0, '0, 1'b0, 1'b1);
    step(4'b0001, 35'h500, 1'b0, 1'b0);
    step(4'b0100, 35'h501, 1'b0, 1'b0);
    chk("pre_rst_valid", bus.out_valid, 1'b1);
    step(4'b0, '0, 1'b0, 1'b1);
    step(4'b0, '0, 1'b1, 1'b0);
    chk("post_rst_valid", bus.out_valid, 1'b0);
    chk("post_rst_credit", bus.rx_vc_credit_gnt, 4'b0000);
    step(4'b1000, 35'h3C, 1'b1, 1'b0);
    chk("fresh_vc", bus.out_vc, 3);
    chk("fresh_pkt", bus.out_packet, 35'h3C);
    step(4'b0, '0, 1'b1, 1'b0);
    chk("fresh_credit", bus.rx_vc_credit_gnt, 4'b1000);

    // Randomized traffic against the model.
    for (int n = 0; n < 600; n++) begin
      a = $urandom_range(0, 15);
      if (a < 10) t = 4'b0001 << $urandom_range(0, 3);
      else if (a == 10) begin
        a = $urandom_range(0, 3);
        t = (4'b0001 << a) | (4'b0001 << ((a + 1) % 4));
      end else t = 4'b0;
      p = {3'($urandom), 32'($urandom)};
      step(t, p, $urandom_range(0, 3) != 0, $urandom_range(0, 79) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
